mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 32, sets the address width of every address port.
REQ-003 Parameter DATA_W, default 32, sets the data width of all data ports; strobe width is DATA_W/8.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mN_req  input  1  master N (N=0,1) requests one transaction.
REQ-007 mN_wen  input  1  1 = write, 0 = read; valid while mN_req=1.
REQ-008 mN_addr  input  ADDR_W  transaction address.
REQ-009 mN_wdata  input  DATA_W  write data.
REQ-010 mN_wstrb  input  DATA_W/8  byte write strobes.
REQ-011 mN_gnt  output  1  request accepted this cycle; master fields are latched on this edge.
REQ-012 mN_rvalid  output  1  one-cycle completion pulse for master N's transaction.
REQ-013 mN_rdata  output  DATA_W  read data, valid only with mN_rvalid.
REQ-014 s_ren / s_wen  output  1 each  read and write enables to the shared data bus.
REQ-015 s_addr / s_wdata / s_wstrb  output  ADDR_W / DATA_W / DATA_W/8  shared bus request fields.
REQ-016 s_rdata  input  DATA_W  shared bus read data, valid one cycle after s_ren.
REQ-017 owner  output  1  index of the master owning the current or last transaction.
REQ-018 busy  output  1  high in ISSUE and RESP states.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on an accepted request, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-020 In IDLE with at least one mN_req high, the arbiter SHALL select one master, assert its mN_gnt combinationally in that cycle, and latch wen, addr, wdata, wstrb and owner.
REQ-021 Selection SHALL be round-robin on register last: a sole requester wins; if both request, the master != last wins.
REQ-022 mN_gnt SHALL be asserted only in IDLE, for at most one master, and for exactly one cycle per transaction.
REQ-023 In ISSUE, the s_* outputs SHALL be driven from the latched fields for exactly one cycle: s_wen=wen, s_ren=~wen, with s_wstrb forced to 0 on reads.
REQ-024 Outside ISSUE, s_ren, s_wen, s_addr, s_wdata and s_wstrb SHALL all be 0.
REQ-025 In RESP, the arbiter SHALL assert m<owner>_rvalid for one cycle; m<owner>_rdata SHALL equal s_rdata on a read and 0 on a write.
REQ-026 The non-owner's rvalid and rdata SHALL be 0 in all states.
REQ-027 On the RESP->IDLE edge, last SHALL be set to owner.
REQ-028 Requests arriving in ISSUE or RESP SHALL be ignored until IDLE; a master SHALL hold req and fields stable until it sees gnt.
REQ-029 Latency SHALL be gnt at cycle T, s_* at T+1, rvalid at T+2, next possible gnt at T+3; sustained throughput SHALL be one transaction per 3 cycles.
REQ-030 mN_req held high after gnt SHALL be treated as a new request in the next IDLE.

Reset
REQ-031 While rst=1 at a clock edge: state<=IDLE, last<=1, owner<=0, and the latched fields are cleared to 0.
REQ-032 With rst=1, all outputs SHALL be 0 from the following cycle.
REQ-033 Reset during ISSUE or RESP SHALL abort the transaction with no rvalid; the first tie after reset SHALL grant m0.

Verification
REQ-034 rst=1 for 2 cycles, then both masters request -> all outputs 0 during reset; first grant goes to m0 (m0_gnt=1, m1_gnt=0).
REQ-035 m0 reads 0x100, memory holds 0xDEADBEEF -> m0_gnt at T; s_ren=1, s_addr=0x100 at T+1; m0_rvalid=1, m0_rdata=0xDEADBEEF at T+2.
REQ-036 m1 writes addr 0x200, wdata 0x12345678, wstrb 0x3 -> at T+1 s_wen=1, s_ren=0 with those exact values; at T+2 m1_rvalid=1, m1_rdata=0.
REQ-037 Both masters hold req continuously for 12 cycles -> grants m0,m1,m0,m1 at cycles T, T+3, T+6, T+9; never two grants in one cycle.
REQ-038 m1 alone holds req continuously -> m1_gnt every 3 cycles; m0 outputs stay 0.
REQ-039 rst=1 in the ISSUE cycle of an m1 read -> no m1_rvalid; all outputs 0 next cycle; a subsequent tie grants m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto a shared single-beat memory bus
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_wen,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_wen,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_ren,
  output logic                s_wen,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                owner,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t                state;
  logic                  last, owner_q, wen_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rd;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  any, sel, idle_ok, iss, rsp;
  // every output is gated by rst so a reset mid-transaction produces no stray pulse
  always_comb begin
    any       = m0_req | m1_req;
    sel       = (m0_req & m1_req) ? ~last : m1_req;
    idle_ok   = (state == IDLE) & ~rst;
    iss       = (state == ISSUE) & ~rst;
    rsp       = (state == RESP) & ~rst;
    m0_gnt    = idle_ok & any & ~sel;
    m1_gnt    = idle_ok & any & sel;
    s_ren     = iss & ~wen_q;
    s_wen     = iss & wen_q;
    s_addr    = iss ? addr_q : '0;
    s_wdata   = iss ? wdata_q : '0;
    s_wstrb   = (iss & wen_q) ? wstrb_q : '0;
    rd        = wen_q ? '0 : s_rdata;
    m0_rvalid = rsp & ~owner_q;
    m1_rvalid = rsp & owner_q;
    m0_rdata  = m0_rvalid ? rd : '0;
    m1_rdata  = m1_rvalid ? rd : '0;
    owner     = owner_q & ~rst;
    busy      = iss | rsp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state   <= ISSUE;
          owner_q <= sel;
          wen_q   <= sel ? m1_wen   : m0_wen;
          addr_q  <= sel ? m1_addr  : m0_addr;
          wdata_q <= sel ? m1_wdata : m0_wdata;
          wstrb_q <= sel ? m1_wstrb : m0_wstrb;
        end
        ISSUE: state <= RESP;
        RESP: begin
          state <= IDLE;
          last  <= owner_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
